// File: rtl/spi_pkg.sv
// Shared parameter defaults and FSM state encoding for the SPI slave block.
package spi_pkg;

   localparam int SPI_DATA_W     = 8;
   localparam int SPI_FIFO_DEPTH = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The pointers carry one extra wrap bit so that full and
// empty can be told apart.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO still fits when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI mode-0 slave, oversampled by clk_i, with an RX FIFO towards the system
// and a TX FIFO supplying the bytes returned to the master.
module spi_slave_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W     = SPI_DATA_W,
   parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sclk_i,
   input  logic              spi_ss_i,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_oe_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              rx_overflow_o,
   output logic              tx_underrun_o,
   input  logic              clear_i
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0] sclk_sync, ss_sync, mosi_sync;
   logic       sclk_d, ss_d;
   logic       sclk_rise, sclk_fall, ss_fall;

   spi_state_e state, state_nxt;
   logic       frame_start, frame_abort, bit_rise, bit_fall;
   logic       byte_done, tx_load;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_sr, rx_byte;
   logic [DATA_W-1:0] tx_sr, tx_next, tx_load_data;
   logic              load_pending;

   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0] tx_head;

   // NOTE: the synchronisers stay out of reset so they keep tracking the pins;
   // an SS held low across reset then cannot masquerade as a fresh falling edge.
   always_ff @(posedge clk_i) begin
      sclk_sync <= {sclk_sync[0], spi_sclk_i};
      ss_sync   <= {ss_sync[0], spi_ss_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      sclk_d    <= sclk_sync[1];
      ss_d      <= ss_sync[1];
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[1] & sclk_d;
   assign ss_fall   = ~ss_sync[1] & ss_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      bit_rise    = 1'b0;
      bit_fall    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_nxt   = ST_SHIFT;
               frame_start = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ss_sync[1]) begin
               state_nxt   = ST_IDLE;
               frame_abort = 1'b1;
            end else begin
               bit_rise = sclk_rise;
               bit_fall = sclk_fall;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign byte_done    = bit_rise && (bit_cnt == LAST_BIT);
   assign rx_byte      = {rx_sr[DATA_W-2:0], mosi_sync[1]};
   assign tx_load      = frame_start || byte_done;
   assign tx_load_data = tx_empty ? '1 : tx_head;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt      <= '0;
         rx_sr        <= '0;
         tx_sr        <= '0;
         tx_next      <= '0;
         load_pending <= 1'b0;
      end else if (frame_start) begin
         bit_cnt      <= '0;
         tx_sr        <= tx_load_data;
         load_pending <= 1'b0;
      end else if (frame_abort) begin
         bit_cnt      <= '0;
         load_pending <= 1'b0;
      end else begin
         if (bit_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_ONE;
         end
         // The reloaded byte waits for the next SCLK fall so MISO never moves after a rise.
         if (byte_done) begin
            tx_next      <= tx_load_data;
            load_pending <= 1'b1;
         end
         if (bit_fall) begin
            if (load_pending) begin
               tx_sr        <= tx_next;
               load_pending <= 1'b0;
            end else begin
               tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
         end
      end
   end

   assign rx_push = byte_done;
   assign rx_pop  = !rx_empty && rx_ready_i;
   assign tx_push = tx_valid_i && !tx_full;
   assign tx_pop  = tx_load && !tx_empty;

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rx_push),
      .data_i  (rx_byte),
      .pop_i   (rx_pop),
      .data_o  (rx_data_o),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (tx_push),
      .data_i  (tx_data_i),
      .pop_i   (tx_pop),
      .data_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   // Sticky flags: a new event in the same cycle as clear_i keeps the flag set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_overflow_o <= 1'b0;
         tx_underrun_o <= 1'b0;
      end else begin
         rx_overflow_o <= (rx_push && rx_full && !rx_pop) || (rx_overflow_o && !clear_i);
         tx_underrun_o <= (tx_load && tx_empty) || (tx_underrun_o && !clear_i);
      end
   end

   assign spi_miso_oe_o = (state == ST_SHIFT);
   assign spi_miso_o    = (state == ST_SHIFT) ? tx_sr[DATA_W-1] : 1'b1;
   assign rx_valid_o    = !rx_empty;
   assign tx_ready_o    = !tx_full;

endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter: DATA_W, 8, SPI frame width in bits (MSB first).
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, entries in each of the RX and TX FIFOs (power of two).
REQ-003 SHALL have ports (name, direction, width, meaning):
  clk_i  in  1  system clock; the only clock; clk_i >= 4x SCLK.
  rst_i  in  1  synchronous reset, active-high.
  spi_sclk_i  in  1  SPI clock from master, asynchronous.
  spi_ss_i  in  1  slave select, active-low, asynchronous.
  spi_mosi_i  in  1  master-out data, asynchronous.
  spi_miso_o  out  1  slave-out data.
  spi_miso_oe_o  out  1  MISO drive enable; high only while SS is active.
  rx_data_o  out  DATA_W  head of RX FIFO.
  rx_valid_o  out  1  RX FIFO non-empty.
  rx_ready_i  in  1  pop RX head when rx_valid_o and rx_ready_i are both high.
  tx_data_i  in  DATA_W  byte to return to master.
  tx_valid_i  in  1  push request to TX FIFO.
  tx_ready_o  out  1  TX FIFO not full.
  rx_overflow_o  out  1  sticky: RX byte dropped.
  tx_underrun_o  out  1  sticky: TX FIFO empty at frame load.
  clear_i  in  1  clears both sticky flags.

Function
REQ-004 SHALL pass spi_sclk_i, spi_ss_i and spi_mosi_i through 2-flop synchronisers, and SHALL detect SCLK edges on the synchronised copy; edge detect SHALL add 1 clk latency (3 clk total from pin).
REQ-005 SHALL implement SPI mode 0: sample MOSI on SCLK rise; update MISO on SCLK fall.
REQ-006 SHALL use FSM states IDLE (SS high) and SHIFT (SS low); SS fall: IDLE->SHIFT; SS rise: any state->IDLE.
REQ-007 On IDLE->SHIFT, SHALL clear bit counter, pop TX head into the TX shift register (0xFF and set tx_underrun_o if TX empty), and drive its MSB on spi_miso_o in the same cycle.
REQ-008 On each SCLK rise in SHIFT, SHALL shift the synchronised MOSI into the RX shift register LSB and increment the 3-bit bit counter (wraps 7->0).
REQ-009 On the 8th rise, SHALL push the assembled byte to RX FIFO in that cycle and reload the TX shift register per REQ-007 rule; the new MSB SHALL appear on the following SCLK fall.
REQ-010 On each other SCLK fall in SHIFT, SHALL shift the TX register left and present the new MSB.
REQ-011 RX push when full without simultaneous pop SHALL drop the byte, keep FIFO contents, and set rx_overflow_o; push and pop in the same cycle when full SHALL be accepted.
REQ-012 rx_valid_o SHALL rise 1 clk after the push cycle; rx_data_o SHALL be valid whenever rx_valid_o is high.
REQ-013 TX push while full SHALL be ignored (tx_ready_o low); simultaneous TX push and frame-load pop SHALL both take effect.
REQ-014 SS rise mid-frame SHALL discard the partial RX byte (no push), reset the bit counter, and lose any already-popped TX byte.
REQ-015 clear_i SHALL clear sticky flags; a set event in the same cycle SHALL win.
REQ-016 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be derived from the MSB compare.

Reset
REQ-017 SHALL, when rst_i is high at clk_i rise, empty both FIFOs, enter IDLE, clear shift registers, counter and sticky flags, and drive spi_miso_o=1, spi_miso_oe_o=0, rx_valid_o=0, tx_ready_o=1.
REQ-018 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh SS fall before shifting.

Structure
REQ-019 DATA_W, FIFO_DEPTH defaults and the FSM state encodings (IDLE=0, SHIFT=1) SHALL live in a shared spi_pkg header.
REQ-020 Both FIFOs SHALL instantiate one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-021 TX preload 0xA5, master sends 0x3C under SS -> rx_data_o=0x3C, rx_valid_o high; master receives 0xA5.
REQ-022 Two-byte burst 0xFF,0x11 with TX empty -> RX holds 0xFF then 0x11; master receives 0xFF,0xFF; tx_underrun_o=1.
REQ-023 Five bytes 0x01..0x05, rx_ready_i=0 -> RX holds 0x01..0x04; rx_overflow_o=1; clear_i -> flag 0.
REQ-024 SS raised after 5 SCLK bits -> no RX push, next frame 0x5A received correctly.
REQ-025 rst_i pulsed mid-frame with 2 RX bytes queued -> rx_valid_o=0, miso_oe=0, next frame 0x77 received correctly.
